// File: rtl/store_buffer.sv
// store_buffer: in-order queue of byte-lane-masked stores that sits between the
// pipeline store stage and the data-memory write port. Each entry holds a word
// address, a 4-bit lane write mask and lane-replicated write data. A drain
// (fence) handshake blocks new stores until the queue is empty and then pulses
// drain_done for one cycle.
// Optional feature: define STORE_BUFFER_ALIGN_CHECK_EN to reject misaligned
// SH/SW stores and report them on misalign_err one cycle later.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [1:0]               st_size,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [3:0]               mem_we,
  output logic [31:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     misalign_err
);

  localparam int AW = $clog2(DEPTH);

  // Store size encodings on st_size.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_SB   = 2'b01;
  localparam logic [1:0] SZ_SH   = 2'b10;
  localparam logic [1:0] SZ_SW   = 2'b11;

  // Drain FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Entry storage. Contents are never reset: occupancy is tracked by r_count,
  // so anything left here at reset is simply unreachable.
  logic [29:0]   r_addr [DEPTH];
  logic [3:0]    r_we   [DEPTH];
  logic [31:0]   r_data [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;

  logic          w_full;
  logic          w_valid;
  logic          w_ready;
  logic          w_misalign;
  logic          w_push;
  logic          w_pop;
  logic          w_empty_next;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;

  // Lane write mask for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_SB:   m = 4'b0001 << off;
      SZ_SH:   m = off[1] ? 4'b1100 : 4'b0011;
      SZ_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the right-justified store data across every lane it may hit,
  // so the memory only needs the mask to pick the right bytes.
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] data);
    logic [31:0] d;
    d = 32'h0;
    case (size)
      SZ_SB:   d = {4{data[7:0]}};
      SZ_SH:   d = {2{data[15:0]}};
      SZ_SW:   d = data;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  // Because DEPTH is a power of two and count never exceeds it, the top count
  // bit alone says the queue is full.
  assign w_full   = r_count[AW];
  assign w_valid  = (r_count != '0);
  assign w_ready  = !w_full && (r_state == ST_IDLE);

  assign w_mask   = lane_mask(st_size, st_addr[1:0]);
  assign w_wdata  = lane_data(st_size, st_data);

`ifdef STORE_BUFFER_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = ((st_size == SZ_SH) && st_addr[0]) ||
                      ((st_size == SZ_SW) && (st_addr[1:0] != 2'b00));

  // Report a rejected misaligned store one cycle after it was offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= st_valid && w_ready && w_misalign;
    end
  end

  assign misalign_err = r_misalign;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign w_push = st_valid && w_ready && (st_size != SZ_NONE) && !w_misalign;
  assign w_pop  = w_valid && mem_ready;

  // True when the queue will be empty after this cycle. No push can happen
  // while draining, so only the pop matters here.
  assign w_empty_next = (r_count == '0) ||
                        ((r_count == (AW+1)'(1)) && w_pop);

  // Write the incoming entry into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= st_addr[31:2];
      r_we[r_wptr]   <= w_mask;
      r_data[r_wptr] <= w_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH since they are exactly AW bits wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM: a fence request blocks new stores until the queue empties,
  // then spends exactly one cycle in DONE to pulse drain_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (drain_req)    r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty_next) r_state <= ST_DONE;
        ST_DONE:                    r_state <= ST_IDLE;
        default:                    r_state <= ST_IDLE;
      endcase
    end
  end

  assign st_ready   = w_ready;
  assign mem_valid  = w_valid;
  assign mem_addr   = {r_addr[r_rptr], 2'b00};
  assign mem_we     = w_valid ? r_we[r_rptr] : 4'b0000;
  assign mem_wdata  = r_data[r_rptr];
  assign count      = r_count;
  assign drain_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: fixed vector table, directed multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [1:0]  st_size = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        mem_ready = 1'b0;
  logic        drain_req = 1'b0;
  logic        st_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        drain_done;
  logic        misalign_err;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_size      (st_size),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .count        (count),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ea;
    logic [3:0]  ewe;
    logic [31:0] ed;
  } vec_t;

  // Reference model state: the queue contents, drain phase (0 idle,
  // 1 draining, 2 done) and the pending misalignment report.
  ent_t q[$];
  int   fsm_m = 0;
  bit   mis_m = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    return ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic ent_t mk(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.addr = a & 32'hFFFF_FFFC;
    e.we   = 4'h0;
    e.data = 32'h0;
    case (sz)
      2'd1: begin
        e.we   = 4'(1 << a[1:0]);
        e.data = {24'd0, d[7:0]} * 32'h0101_0101;
      end
      2'd2: begin
        e.we   = a[1] ? 4'hC : 4'h3;
        e.data = {16'd0, d[15:0]} * 32'h0001_0001;
      end
      2'd3: begin
        e.we   = 4'hF;
        e.data = d;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".count"},     32'(count),      32'(q.size()));
    chk({tag, ".st_ready"},  32'(st_ready),   32'((q.size() < DEPTH) && (fsm_m == 0)));
    chk({tag, ".mem_valid"}, 32'(mem_valid),  32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".mem_addr"},  mem_addr,        q[0].addr);
      chk({tag, ".mem_we"},    32'(mem_we),     32'(q[0].we));
      chk({tag, ".mem_wdata"}, mem_wdata,       q[0].data);
    end else begin
      chk({tag, ".mem_we_idle"}, 32'(mem_we), 32'h0);
    end
    chk({tag, ".drain_done"},   32'(drain_done),   32'(fsm_m == 2));
    chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(mis_m));
  endtask

  // Check the current outputs, advance the model by one clock, then clock the DUT.
  task automatic cycle(input string tag);
    bit rdy, mis, push, pop;
    check_model(tag);
    rdy  = (q.size() < DEPTH) && (fsm_m == 0);
    mis  = misaligned(st_size, st_addr);
    push = st_valid && rdy && (st_size != 2'd0) && !mis;
    pop  = (q.size() > 0) && mem_ready;
    case (fsm_m)
      0: if (drain_req) fsm_m = 1;
      1: if ((q.size() - int'(pop)) == 0) fsm_m = 2;
      default: fsm_m = 0;
    endcase
    mis_m = st_valid && rdy && mis;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(mk(st_size, st_addr, st_data));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    st_valid  = 1'b0;
    st_size   = 2'd0;
    drain_req = 1'b0;
  endtask

  task automatic put(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst.count",        32'(count),        32'h0);
    chk("rst.mem_valid",    32'(mem_valid),    32'h0);
    chk("rst.mem_we",       32'(mem_we),       32'h0);
    chk("rst.drain_done",   32'(drain_done),   32'h0);
    chk("rst.misalign_err", 32'(misalign_err), 32'h0);
    q.delete();
    fsm_m = 0;
    mis_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst.st_ready", 32'(st_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic [31:0] ord [5];
    int          idx, ndone, zero_at, done_at;
    bit          sent;

    tbl[0] = '{2'd1, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
    tbl[1] = '{2'd1, 32'h0000_0010, 32'h1234_56C3, 32'h0000_0010, 4'b0001, 32'hC3C3_C3C3};
    tbl[2] = '{2'd1, 32'h0000_0021, 32'h0000_005A, 32'h0000_0020, 4'b0010, 32'h5A5A_5A5A};
    tbl[3] = '{2'd1, 32'h0000_0032, 32'hFFFF_FF77, 32'h0000_0030, 4'b0100, 32'h7777_7777};
    tbl[4] = '{2'd2, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF};
    tbl[5] = '{2'd2, 32'h0000_4000, 32'h9999_A55A, 32'h0000_4000, 4'b0011, 32'hA55A_A55A};
    tbl[6] = '{2'd3, 32'h0000_2004, 32'hCAFE_F00D, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D};
    tbl[7] = '{2'd3, 32'hFFFF_FFFC, 32'h8000_0001, 32'hFFFF_FFFC, 4'b1111, 32'h8000_0001};

    do_reset();

    // Single stores from empty: visible on the write port the next cycle.
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0;
      put(tbl[i].sz, tbl[i].a, tbl[i].d);
      cycle("tbl_push");
      idle_in();
      chk("tbl.mem_valid", 32'(mem_valid), 32'h1);
      chk("tbl.mem_addr",  mem_addr,       tbl[i].ea);
      chk("tbl.mem_we",    32'(mem_we),    32'(tbl[i].ewe));
      chk("tbl.mem_wdata", mem_wdata,      tbl[i].ed);
      mem_ready = 1'b1;
      cycle("tbl_pop");
    end
    mem_ready = 1'b0;
    cycle("tbl_empty");

    // Size 00 with st_valid changes nothing.
    put(2'd0, 32'h0000_0500, 32'h1111_1111);
    cycle("none_sz");
    chk("none_sz.count", 32'(count), 32'h0);
    idle_in();

    // SH then SW back to back with the memory always ready.
    mem_ready = 1'b1;
    put(2'd2, 32'h0000_2002, 32'h1234_BEEF);
    cycle("order_sh");
    chk("order.first_we",    32'(mem_we), 32'hC);
    chk("order.first_wdata", mem_wdata,   32'hBEEF_BEEF);
    put(2'd3, 32'h0000_2004, 32'hCAFE_F00D);
    cycle("order_sw");
    idle_in();
    chk("order.second_we",    32'(mem_we), 32'hF);
    chk("order.second_wdata", mem_wdata,   32'hCAFE_F00D);
    cycle("order_pop");
    cycle("order_empty");

    // Fill to DEPTH, hold a fifth store, then drain across the pointer wrap.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ord[i] = 32'hA0 + 32'(i);
      put(2'd3, 32'h0000_0100 + 32'(4 * i), ord[i]);
      cycle("fill");
    end
    ord[4] = 32'h0000_0055;
    chk("full.count",    32'(count),    32'h4);
    chk("full.st_ready", 32'(st_ready), 32'h0);
    put(2'd3, 32'h0000_0200, ord[4]);
    cycle("held");
    chk("held.count", 32'(count), 32'h4);
    mem_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_valid) begin
        if (idx < 5) chk("wrap.order", mem_wdata, ord[idx]);
        else fail_now("wrap.extra_pop", idx, 4);
        idx++;
      end
      sent = st_valid && st_ready;
      cycle("wrap");
      if (i == 0) chk("wrap.ready_after_pop", 32'(st_ready), 32'h1);
      if (sent) idle_in();
    end
    chk("wrap.total", 32'(idx), 32'd5);

    // Drain with three entries queued; a second request mid-drain is ignored.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(2'd1, 32'h0000_0600 + 32'(i), 32'h10 + 32'(i));
      cycle("drain_fill");
    end
    idle_in();
    mem_ready = 1'b1;
    drain_req = 1'b1;
    cycle("drain_req");
    drain_req = 1'b0;
    ndone = 0;
    zero_at = -1;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      if ((count == 3'd0) && (zero_at < 0)) zero_at = i;
      if (drain_done) begin
        ndone++;
        done_at = i;
      end
      if (done_at < 0) chk("drain.st_ready", 32'(st_ready), 32'h0);
      drain_req = (i == 1);
      cycle("drain");
      drain_req = 1'b0;
    end
    chk("drain.pulses", 32'(ndone), 32'd1);
    if (zero_at < 0) fail_now("drain.never_empty", zero_at, 0);
    else chk("drain.done_when_empty", 32'(done_at), 32'(zero_at));

    // Drain while empty: one DRAIN cycle, then DONE.
    drain_req = 1'b1;
    cycle("edrain_req");
    drain_req = 1'b0;
    chk("edrain.drain_phase_done", 32'(drain_done), 32'h0);
    chk("edrain.drain_phase_rdy",  32'(st_ready),   32'h0);
    cycle("edrain_drain");
    chk("edrain.done", 32'(drain_done), 32'h1);
    cycle("edrain_done");
    cycle("edrain_idle");

    // Reset with two entries pending; nothing may issue afterwards.
    mem_ready = 1'b0;
    put(2'd3, 32'h0000_0700, 32'hDEAD_0001);
    cycle("rst_fill");
    put(2'd3, 32'h0000_0704, 32'hDEAD_0002);
    cycle("rst_fill");
    idle_in();
    chk("rst_pre.count", 32'(count), 32'h2);
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // Misaligned SW.
    mem_ready = 1'b0;
    put(2'd3, 32'h0000_3002, 32'h1234_5678);
    cycle("mis_sw");
    idle_in();
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    chk("mis.count",     32'(count),        32'h0);
    chk("mis.err",       32'(misalign_err), 32'h1);
    cycle("mis_after");
    chk("mis.err_clear", 32'(misalign_err), 32'h0);
`else
    chk("mis.count",    32'(count),        32'h1);
    chk("mis.mem_addr", mem_addr,          32'h0000_3000);
    chk("mis.mem_we",   32'(mem_we),       32'hF);
    chk("mis.err",      32'(misalign_err), 32'h0);
    mem_ready = 1'b1;
    cycle("mis_pop");
`endif
    cycle("mis_end");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_size   = 2'($urandom_range(0, 3));
      st_addr   = $urandom;
      st_data   = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
      drain_req = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    idle_in();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle("rand_flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
